// File: rtl/decode_pkg.sv
// Shared MIPS decode constants: opcode values, instruction field positions
// and the opcode classifiers used by the decode stage.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int OPCODE_W   = 6;
  localparam int FUNCT_W    = 6;
  localparam int IMM_W      = 16;

  // Opcodes that consume rt as a source (R-type ALU, branches, store).
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

  function automatic logic is_logical_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return op == OP_LW;
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with hardwired zero register and an
// optional same-cycle write-through path to both read ports.
module reg_file_2r1w #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int BYPASS    = 1,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [REG_COUNT];
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  // Write-through only when enabled; the zero register never forwards.
  always_comb begin
    rdata1 = mem[raddr1];
    rdata2 = mem[raddr2];
    if (BYPASS != 0 && wr_en && waddr == raddr1) rdata1 = wdata;
    if (BYPASS != 0 && wr_en && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/decode_stage_p.sv
// Pipelined MIPS decode: field extraction, immediate extension, load-use
// hazard detection and the ID/EX register with bubble and flush handling.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int BYPASS    = 1,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              In_Valid,
  input  logic [31:0]       Instruction,
  input  logic              Flush,
  input  logic              WB_RegWrite,
  input  logic [AW-1:0]     WB_Addr,
  input  logic [DATA_W-1:0] WB_Data,
  input  logic              EX_MemRead,
  input  logic [AW-1:0]     EX_Rt,
  output logic              Stall,
  output logic              Out_Valid,
  output logic [5:0]        Opcode,
  output logic [5:0]        Funct,
  output logic [DATA_W-1:0] Read_Data_1,
  output logic [DATA_W-1:0] Read_Data_2,
  output logic [DATA_W-1:0] Sign_Extended_Immediate,
  output logic [AW-1:0]     Rs,
  output logic [AW-1:0]     Rt,
  output logic [AW-1:0]     Rd
);

  function automatic logic signed [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] imm,
                                                          input logic zext);
    logic signed [DATA_W-1:0] res;
    if (zext) res = DATA_W'(imm);
    else      res = DATA_W'($signed(imm));
    return res;
  endfunction

  // ---- stage p0: decode from the IF/ID word ----
  logic [5:0]               opcode_p0;
  logic [5:0]               funct_p0;
  logic [AW-1:0]            rs_p0;
  logic [AW-1:0]            rt_p0;
  logic [AW-1:0]            rd_p0;
  logic [IMM_W-1:0]         imm_p0;
  logic [DATA_W-1:0]        rf_rd1;
  logic [DATA_W-1:0]        rf_rd2;
  logic signed [DATA_W-1:0] rd1_p0;
  logic signed [DATA_W-1:0] rd2_p0;
  logic signed [DATA_W-1:0] ext_p0;
  logic                     hazard_p0;

  assign opcode_p0 = Instruction[OPCODE_LSB +: OPCODE_W];
  assign funct_p0  = Instruction[FUNCT_LSB +: FUNCT_W];
  assign rs_p0     = Instruction[RS_LSB +: AW];
  assign rt_p0     = Instruction[RT_LSB +: AW];
  assign rd_p0     = Instruction[RD_LSB +: AW];
  assign imm_p0    = Instruction[IMM_LSB +: IMM_W];

  reg_file_2r1w #(
    .DATA_W   (DATA_W),
    .REG_COUNT(REG_COUNT),
    .BYPASS   (BYPASS)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (WB_RegWrite),
    .waddr (WB_Addr),
    .wdata (WB_Data),
    .raddr1(rs_p0),
    .raddr2(rt_p0),
    .rdata1(rf_rd1),
    .rdata2(rf_rd2)
  );

  assign rd1_p0 = $signed(rf_rd1);
  assign rd2_p0 = $signed(rf_rd2);
  assign ext_p0 = extend_imm(imm_p0, is_logical_imm(opcode_p0));

  // Loads into r0 never create a dependency.
  assign hazard_p0 = In_Valid && EX_MemRead && (EX_Rt != '0) &&
                     ((EX_Rt == rs_p0) || (uses_rt(opcode_p0) && (EX_Rt == rt_p0)));
  assign Stall     = hazard_p0 && !Flush;

  // ---- stage p1: ID/EX register ----
  logic                     vld_p1;
  logic [5:0]               opcode_p1;
  logic [5:0]               funct_p1;
  logic [AW-1:0]            rs_p1;
  logic [AW-1:0]            rt_p1;
  logic [AW-1:0]            rd_p1;
  logic signed [DATA_W-1:0] rd1_p1;
  logic signed [DATA_W-1:0] rd2_p1;
  logic signed [DATA_W-1:0] ext_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      opcode_p1 <= '0;
      funct_p1  <= '0;
      rs_p1     <= '0;
      rt_p1     <= '0;
      rd_p1     <= '0;
      rd1_p1    <= '0;
      rd2_p1    <= '0;
      ext_p1    <= '0;
    end else if (Flush || hazard_p0) begin
      vld_p1    <= 1'b0;
      opcode_p1 <= '0;
      funct_p1  <= '0;
      rs_p1     <= '0;
      rt_p1     <= '0;
      rd_p1     <= '0;
      rd1_p1    <= '0;
      rd2_p1    <= '0;
      ext_p1    <= '0;
    end else begin
      vld_p1    <= In_Valid;
      opcode_p1 <= opcode_p0;
      funct_p1  <= funct_p0;
      rs_p1     <= rs_p0;
      rt_p1     <= rt_p0;
      rd_p1     <= rd_p0;
      rd1_p1    <= rd1_p0;
      rd2_p1    <= rd2_p0;
      ext_p1    <= ext_p0;
    end
  end

  assign Out_Valid               = vld_p1;
  assign Opcode                  = opcode_p1;
  assign Funct                   = funct_p1;
  assign Rs                      = rs_p1;
  assign Rt                      = rt_p1;
  assign Rd                      = rd_p1;
  assign Read_Data_1             = $unsigned(rd1_p1);
  assign Read_Data_2             = $unsigned(rd2_p1);
  assign Sign_Extended_Immediate = $unsigned(ext_p1);

endmodule
